imem_boot_loader: RTL and testbench

//  Boot-time program loader sitting upstream of the 5-stage core's instruction SRAM (2048x32, active-low WEn).

---
 rtl/boot_pkg.sv | 41 ++++
 rtl/boot_sram_wr_port.sv | 53 +++++
 rtl/imem_boot_loader.sv | 197 +++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
//   boot_state_t       : loader FSM state encoding
//   BOOT_DEPTH         : instruction SRAM words, also the largest legal LENGTH
//   BOOT_ADDR_W        : instruction SRAM address width
//   BOOT_WIDTH         : stream / SRAM data word width
//   boot_csum_fold()   : folds one payload word into the running XOR checksum
//   boot_state_accepts(): states in which the stream port is ready
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    LOAD  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } boot_state_t;

  localparam int BOOT_DEPTH  = 2048;
  localparam int BOOT_ADDR_W = 11;
  localparam int BOOT_WIDTH  = 32;

  // Running frame checksum is a plain XOR of every payload word.
  function automatic logic [BOOT_WIDTH-1:0] boot_csum_fold(
    input logic [BOOT_WIDTH-1:0] acc,
    input logic [BOOT_WIDTH-1:0] word
  );
    return acc ^ word;
  endfunction

  // The stream port takes words only while a frame is in flight.
  function automatic logic boot_state_accepts(input boot_state_t st);
    logic acc_s;
    case (st)
      LEN, LOAD, CHECK: acc_s = 1'b1;
      default:          acc_s = 1'b0;
    endcase
    return acc_s;
  endfunction

endpackage

// File: rtl/boot_sram_wr_port.sv
// Registered SRAM write-port strobe generator for the boot loader.
// A write request in cycle N becomes a one-cycle active-low CEn/WEn strobe
// with matching address/data in cycle N+1; strobes return high otherwise.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   wr_en             request a write this cycle
//   wr_addr, wr_data  address / data of the requested write
//   mem_cen, mem_wen  SRAM chip / write enable, active-low, registered
//   mem_a, mem_d      SRAM address / write data, registered
module boot_sram_wr_port #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_a,
  output logic [WIDTH-1:0]  mem_d
);

  logic              cen_r;
  logic              wen_r;
  logic [ADDR_W-1:0] a_r;
  logic [WIDTH-1:0]  d_r;

  // Strobe register: one-cycle write pulse per request, A/D held between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cen_r <= 1'b1;
      wen_r <= 1'b1;
      a_r   <= {ADDR_W{1'b0}};
      d_r   <= {WIDTH{1'b0}};
    end else if (wr_en) begin
      cen_r <= 1'b0;
      wen_r <= 1'b0;
      a_r   <= wr_addr;
      d_r   <= wr_data;
    end else begin
      cen_r <= 1'b1;
      wen_r <= 1'b1;
    end
  end

  assign mem_cen = cen_r;
  assign mem_wen = wen_r;
  assign mem_a   = a_r;
  assign mem_d   = d_r;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot-time program loader for the core's instruction SRAM.
// Receives a framed stream (LENGTH, LENGTH payload words, XOR checksum) on a
// valid/ready port, writes the payload to SRAM addresses 0..LENGTH-1 and
// releases the core from reset only when the checksum matches.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   start          one-cycle pulse, begins a load from IDLE/DONE/ERROR
//   s_valid/s_data stream word offered by the source
//   s_ready        loader consumes s_data this cycle when s_valid is high
//   mem_cen/wen    SRAM strobes, active-low, one cycle per write
//   mem_a/mem_d    SRAM address / write data
//   core_rst       active-low core reset, high only after a good load
//   busy           frame in flight (LEN, LOAD, CHECK)
//   done / error   load passed / load failed (error sticky until start)
//   words_loaded   payload words written in the current frame
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int WIDTH  = BOOT_WIDTH,
  parameter int ADDR_W = BOOT_ADDR_W,
  parameter int DEPTH  = BOOT_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [WIDTH-1:0]  s_data,
  output logic              s_ready,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_a,
  output logic [WIDTH-1:0]  mem_d,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CNT_W = ADDR_W + 1;

  boot_state_t      state_r;
  boot_state_t      state_nxt_s;
  logic [CNT_W-1:0] length_r;
  logic [CNT_W-1:0] words_loaded_r;
  logic [WIDTH-1:0] checksum_r;
  logic             s_ready_r;
  logic             busy_r;
  logic             done_r;
  logic             error_r;
  logic             core_rst_r;

  logic             xfer_s;
  logic             start_ok_s;
  logic             len_xfer_s;
  logic             load_xfer_s;
  logic             last_word_s;
  logic             len_zero_s;
  logic             len_over_s;
  logic             csum_ok_s;
  logic [CNT_W-1:0] words_inc_s;

  // s_ready is registered from the next state, so a transfer is simply
  // valid & ready with no combinational path from s_valid back to s_ready.
  assign xfer_s      = s_valid & s_ready_r;
  assign start_ok_s  = start & ((state_r == IDLE) | (state_r == DONE) | (state_r == ERROR));
  assign len_xfer_s  = xfer_s & (state_r == LEN);
  assign load_xfer_s = xfer_s & (state_r == LOAD);
  assign words_inc_s = words_loaded_r + CNT_W'(1);
  // >= rather than == so a corrupted count can never run the frame past LENGTH.
  assign last_word_s = (words_inc_s >= length_r);
  assign len_zero_s  = (s_data == WIDTH'(0));
  assign len_over_s  = (s_data > WIDTH'(DEPTH));
  assign csum_ok_s   = (s_data == checksum_r);

  // Next-state logic of the frame FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_nxt_s = LEN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      LEN: begin
        if (xfer_s) begin
          if (len_zero_s) begin
            state_nxt_s = CHECK;
          end else if (len_over_s) begin
            state_nxt_s = ERROR;
          end else begin
            state_nxt_s = LOAD;
          end
        end else begin
          state_nxt_s = LEN;
        end
      end
      LOAD: begin
        if (xfer_s && last_word_s) begin
          state_nxt_s = CHECK;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      CHECK: begin
        if (xfer_s) begin
          if (csum_ok_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = ERROR;
          end
        end else begin
          state_nxt_s = CHECK;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register plus status outputs registered from the next state, so
  // done/core_rst rise the cycle after the checksum transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      s_ready_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      core_rst_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      s_ready_r  <= boot_state_accepts(state_nxt_s);
      busy_r     <= boot_state_accepts(state_nxt_s);
      done_r     <= (state_nxt_s == DONE);
      error_r    <= (state_nxt_s == ERROR);
      core_rst_r <= (state_nxt_s == DONE);
    end
  end

  // Frame length: only the low CNT_W bits matter, oversize lengths go to ERROR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      length_r <= {CNT_W{1'b0}};
    end else if (start_ok_s) begin
      length_r <= {CNT_W{1'b0}};
    end else if (len_xfer_s) begin
      length_r <= s_data[CNT_W-1:0];
    end else begin
      length_r <= length_r;
    end
  end

  // Running XOR checksum and saturating payload word counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum_r     <= {WIDTH{1'b0}};
      words_loaded_r <= {CNT_W{1'b0}};
    end else if (start_ok_s) begin
      checksum_r     <= {WIDTH{1'b0}};
      words_loaded_r <= {CNT_W{1'b0}};
    end else if (load_xfer_s && (words_loaded_r < length_r)) begin
      checksum_r     <= boot_csum_fold(checksum_r, s_data);
      words_loaded_r <= words_inc_s;
    end else begin
      checksum_r     <= checksum_r;
      words_loaded_r <= words_loaded_r;
    end
  end

  // Each accepted payload word is written at the current word index.
  boot_sram_wr_port #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_wr_port (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (load_xfer_s),
    .wr_addr (words_loaded_r[ADDR_W-1:0]),
    .wr_data (s_data),
    .mem_cen (mem_cen),
    .mem_wen (mem_wen),
    .mem_a   (mem_a),
    .mem_d   (mem_d)
  );

  assign s_ready      = s_ready_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign error        = error_r;
  assign core_rst     = core_rst_r;
  assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader. Every payload word driven is pushed as
// {address, data} onto a scoreboard queue; a negedge monitor pops and compares
// each SRAM write strobe it observes. Status outputs are checked at fixed
// points in the directed sequence.
module tb_imem_boot_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        mem_cen;
  logic        mem_wen;
  logic [10:0] mem_a;
  logic [31:0] mem_d;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        error;
  logic [11:0] words_loaded;

  int          errors;
  int          checks;
  int          wr_cnt;
  logic [42:0] exp_q[$];
  logic [31:0] pay[64];

  imem_boot_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .mem_cen      (mem_cen),
    .mem_wen      (mem_wen),
    .mem_a        (mem_a),
    .mem_d        (mem_d),
    .core_rst     (core_rst),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst === 1'b1 && mem_cen === 1'b0 && mem_wen === 1'b0) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 64'(mem_a), 64'hFFFF_FFFF);
      end else begin
        logic [42:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_a), 64'(e[42:32]));
        check("wr_data", 64'(mem_d), 64'(e[31:0]));
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Offer one word and hold it until the loader takes it (bounded wait).
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    check("ready_wait", 64'(s_ready), 64'(1'b1));
    tick(1);
    s_valid = 1'b0;
  endtask

  // Full frame from pay[]; the good checksum is the XOR of the payload.
  task automatic run_frame(input int len, input bit gaps, input bit bad_csum);
    logic [31:0] csum;
    csum = 32'h0;
    send_word(32'(len));
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({11'(i), pay[i]});
      csum = csum ^ pay[i];
      if (gaps && $urandom_range(0, 1) == 1) begin
        s_valid = 1'b0;
        tick(1);
      end
      send_word(pay[i]);
    end
    send_word(bad_csum ? 32'hDEAD_BEEF : csum);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"},  64'(s_ready),      64'(1'b0));
    check({tag, "_mem_cen"},  64'(mem_cen),      64'(1'b1));
    check({tag, "_mem_wen"},  64'(mem_wen),      64'(1'b1));
    check({tag, "_mem_a"},    64'(mem_a),        64'(11'd0));
    check({tag, "_mem_d"},    64'(mem_d),        64'(32'd0));
    check({tag, "_core_rst"}, 64'(core_rst),     64'(1'b0));
    check({tag, "_busy"},     64'(busy),         64'(1'b0));
    check({tag, "_done"},     64'(done),         64'(1'b0));
    check({tag, "_error"},    64'(error),        64'(1'b0));
    check({tag, "_words"},    64'(words_loaded), 64'(12'd0));
  endtask

  initial begin
    int w0;
    errors  = 0;
    checks  = 0;
    wr_cnt  = 0;
    rst     = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 32'h0;
    tick(3);
    check_reset_vals("reset");
    rst = 1'b1;
    tick(2);

    // Test 1: three-instruction program with a good checksum.
    pay[0] = 32'h0050_0093;
    pay[1] = 32'h00A0_0113;
    pay[2] = 32'h0020_81B3;
    w0 = wr_cnt;
    pulse_start();
    check("t1_busy_in_len", 64'(busy), 64'(1'b1));
    check("t1_ready_in_len", 64'(s_ready), 64'(1'b1));
    run_frame(3, 1'b0, 1'b0);
    check("t1_done", 64'(done), 64'(1'b1));
    check("t1_core_rst", 64'(core_rst), 64'(1'b1));
    check("t1_error", 64'(error), 64'(1'b0));
    check("t1_ready_low", 64'(s_ready), 64'(1'b0));
    tick(2);
    check("t1_writes", 64'(wr_cnt - w0), 64'(3));
    check("t1_words", 64'(words_loaded), 64'(12'd3));
    check("t1_queue_empty", 64'(exp_q.size()), 64'(0));

    // Test 2: same frame, wrong checksum.
    w0 = wr_cnt;
    pulse_start();
    check("t2_core_rst_dropped", 64'(core_rst), 64'(1'b0));
    run_frame(3, 1'b0, 1'b1);
    check("t2_error", 64'(error), 64'(1'b1));
    check("t2_core_rst", 64'(core_rst), 64'(1'b0));
    check("t2_done", 64'(done), 64'(1'b0));
    check("t2_words", 64'(words_loaded), 64'(12'd3));
    tick(2);
    check("t2_writes", 64'(wr_cnt - w0), 64'(3));
    check("t2_error_sticky", 64'(error), 64'(1'b1));

    // Test 3a: empty frame with zero checksum.
    w0 = wr_cnt;
    pulse_start();
    check("t3_error_cleared", 64'(error), 64'(1'b0));
    run_frame(0, 1'b0, 1'b0);
    check("t3_zero_done", 64'(done), 64'(1'b1));
    check("t3_zero_core_rst", 64'(core_rst), 64'(1'b1));
    // Test 3b: LENGTH one beyond the SRAM depth.
    pulse_start();
    send_word(32'd2049);
    check("t3_over_error", 64'(error), 64'(1'b1));
    check("t3_over_ready", 64'(s_ready), 64'(1'b0));
    check("t3_over_busy", 64'(busy), 64'(1'b0));
    tick(2);
    check("t3_writes", 64'(wr_cnt - w0), 64'(0));

    // Test 4: 64-word random frame with ~50% valid gaps.
    for (int i = 0; i < 64; i++) pay[i] = $urandom();
    w0 = wr_cnt;
    pulse_start();
    run_frame(64, 1'b1, 1'b0);
    check("t4_done", 64'(done), 64'(1'b1));
    tick(2);
    check("t4_writes", 64'(wr_cnt - w0), 64'(64));
    check("t4_words", 64'(words_loaded), 64'(12'd64));
    check("t4_queue_empty", 64'(exp_q.size()), 64'(0));

    // Test 5: async reset after word 10 of a 20-word frame.
    pulse_start();
    send_word(32'd20);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({11'(i), pay[i]});
      send_word(pay[i]);
    end
    check("t5_words_mid", 64'(words_loaded), 64'(12'd10));
    check("t5_strobe_mid", 64'(mem_wen), 64'(1'b0));
    rst = 1'b0;
    #1;
    check_reset_vals("t5_async");
    exp_q.delete();
    tick(2);
    rst = 1'b1;
    tick(1);
    pay[0] = 32'h0050_0093;
    pay[1] = 32'h00A0_0113;
    pay[2] = 32'h0020_81B3;
    pulse_start();
    run_frame(3, 1'b0, 1'b0);
    check("t5_done_after", 64'(done), 64'(1'b1));
    tick(2);

    // Test 6: start during LOAD is ignored; start in DONE restarts.
    pay[3] = 32'h1234_5678;
    pulse_start();
    send_word(32'd4);
    exp_q.push_back({11'd0, pay[0]});
    send_word(pay[0]);
    exp_q.push_back({11'd1, pay[1]});
    send_word(pay[1]);
    pulse_start();
    check("t6_busy_kept", 64'(busy), 64'(1'b1));
    check("t6_words_kept", 64'(words_loaded), 64'(12'd2));
    exp_q.push_back({11'd2, pay[2]});
    send_word(pay[2]);
    exp_q.push_back({11'd3, pay[3]});
    send_word(pay[3]);
    send_word(pay[0] ^ pay[1] ^ pay[2] ^ pay[3]);
    check("t6_done", 64'(done), 64'(1'b1));
    check("t6_words", 64'(words_loaded), 64'(12'd4));
    tick(1);
    pulse_start();
    check("t6_restart_core_rst", 64'(core_rst), 64'(1'b0));
    check("t6_restart_done", 64'(done), 64'(1'b0));
    check("t6_restart_ready", 64'(s_ready), 64'(1'b1));
    check("t6_restart_words", 64'(words_loaded), 64'(12'd0));
    run_frame(0, 1'b0, 1'b0);
    check("t6_final_done", 64'(done), 64'(1'b1));
    tick(2);
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
